// File: rtl/alu_16bit.sv
// Execute-stage ALU with all outputs registered: 1-cycle latency, one op accepted every cycle, no backpressure.
// Define ALU_OVERFLOW_EN to build the overflow register; otherwise overflow is tied to 0.
module alu_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             ainvert,
  input  logic             bnegate,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  logic [WIDTH-1:0] aa, bb, s;
  logic             c16, v;
  logic [WIDTH-1:0] result_d, result_q;
  logic             cout_d, cout_q;
  logic             zero_d, zero_q;

  always_comb begin
    aa       = ainvert ? ~a : a;
    bb       = bnegate ? ~b : b;
    {c16, s} = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
    // v feeds SLT even when the overflow output is not built
    v        = (aa[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != aa[WIDTH-1]);
  end

  always_comb begin
    result_d = '0;
    cout_d   = 1'b0;
    unique case (op)
      3'b000: result_d = aa & bb;
      3'b001: result_d = aa | bb;
      3'b010: begin
        result_d = s;
        cout_d   = c16;
      end
      3'b011: begin
        result_d = {{(WIDTH-1){1'b0}}, s[WIDTH-1] ^ v};
        cout_d   = c16;
      end
      3'b100: result_d = aa ^ bb;
      3'b101: result_d = aa | bb;
      3'b110: begin
        result_d = {{(WIDTH-1){1'b0}}, ~c16};
        cout_d   = c16;
      end
      default: result_d = bb;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = 1'b0;
    if (op == 3'b010 || op == 3'b011) ovf_d = v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_16bit.sv
// Directed and back-to-back checks of alu_16bit against a scoreboard of expected outputs.
module tb_alu_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        cin, ainvert, bnegate;
  logic [2:0]  op;
  logic [15:0] result;
  logic        cout, zero, overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        z;
    logic        ov;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  alu_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin),
    .ainvert(ainvert), .bnegate(bnegate), .op(op),
    .result(result), .cout(cout), .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic ovf_en(input logic x);
`ifdef ALU_OVERFLOW_EN
    return x;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: unsigned sum for carry, signed integer range test for overflow.
  function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                                 input logic ai, input logic bn, input logic [2:0] iop);
    exp_t e;
    int unsigned ua, ub, us;
    int sa, sb, ss;
    logic v, c;
    logic [15:0] sum;
    ua  = ai ? (32'hFFFF ^ ia) : ia;
    ub  = bn ? (32'hFFFF ^ ib) : ib;
    us  = ua + ub + ic;
    sum = us[15:0];
    c   = us[16];
    sa  = (ua >= 32768) ? int'(ua) - 65536 : int'(ua);
    sb  = (ub >= 32768) ? int'(ub) - 65536 : int'(ub);
    ss  = sa + sb + int'(ic);
    v   = (ss > 32767) || (ss < -32768);
    e.co = 1'b0;
    e.ov = 1'b0;
    case (iop)
      3'd0: e.res = ua[15:0] & ub[15:0];
      3'd1, 3'd5: e.res = ua[15:0] | ub[15:0];
      3'd2: begin e.res = sum; e.co = c; e.ov = ovf_en(v); end
      3'd3: begin e.res = (sa + sb + int'(ic) < 0) ? 16'd1 : 16'd0; e.co = c; e.ov = ovf_en(v); end
      3'd4: e.res = ua[15:0] ^ ub[15:0];
      3'd6: begin e.res = (us < 65536) ? 16'd1 : 16'd0; e.co = c; end
      default: e.res = ub[15:0];
    endcase
    // Raw SLT reports s[15]^v, which equals the true sign of the unbounded sum
    e.z   = (e.res == 16'h0000);
    e.tag = "model";
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input exp_t e);
    check({e.tag, ".result"}, result, e.res);
    check({e.tag, ".cout"}, {15'd0, cout}, {15'd0, e.co});
    check({e.tag, ".zero"}, {15'd0, zero}, {15'd0, e.z});
    check({e.tag, ".overflow"}, {15'd0, overflow}, {15'd0, e.ov});
  endtask

  task automatic drive(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input logic ai, input logic bn, input logic [2:0] iop);
    a = ia; b = ib; cin = ic; ainvert = ai; bnegate = bn; op = iop;
  endtask

  // Drive, queue expectation, then compare 1 ns after the capturing edge.
  task automatic step(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic ai, input logic bn, input logic [2:0] iop,
                      input logic [15:0] r, input logic co, input logic z, input logic ov);
    exp_t e;
    drive(ia, ib, ic, ai, bn, iop);
    e.res = r; e.co = co; e.z = z; e.ov = ov; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    // Glitch on inputs between edges must not reach the registers
    a = ~ia; b = ~ib;
    #1;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: observed empty scoreboard expected entry", tag);
    end else check_out(exp_q.pop_front());
  endtask

  task automatic step_model(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                            input logic ic, input logic ai, input logic bn, input logic [2:0] iop);
    exp_t e;
    e = model(ia, ib, ic, ai, bn, iop);
    step(tag, ia, ib, ic, ai, bn, iop, e.res, e.co, e.z, e.ov);
  endtask

  initial begin
    exp_t r0;
    rst = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    r0.res = 16'h0; r0.co = 1'b0; r0.z = 1'b1; r0.ov = 1'b0; r0.tag = "reset";
    #2;
    check_out(r0);
    @(negedge clk);
    rst = 1'b0;

    // AND
    step("and00", 16'h0, 16'h0, 0, 0, 0, 3'b000, 16'h0, 0, 1, 0);
    step("and10", 16'h1, 16'h0, 0, 0, 0, 3'b000, 16'h0, 0, 1, 0);
    step("and11", 16'h1, 16'h1, 0, 0, 0, 3'b000, 16'h1, 0, 0, 0);
    // OR, both encodings
    step("or5_00", 16'h0, 16'h0, 0, 0, 0, 3'b101, 16'h0, 0, 1, 0);
    step("or5_10", 16'h1, 16'h0, 0, 0, 0, 3'b101, 16'h1, 0, 0, 0);
    step("or5_11", 16'h1, 16'h1, 0, 0, 0, 3'b101, 16'h1, 0, 0, 0);
    step("or1_00", 16'h0, 16'h0, 0, 0, 0, 3'b001, 16'h0, 0, 1, 0);
    step("or1_10", 16'h1, 16'h0, 0, 0, 0, 3'b001, 16'h1, 0, 0, 0);
    step("or1_11", 16'h1, 16'h1, 0, 0, 0, 3'b001, 16'h1, 0, 0, 0);
    // ADD / SUB
    step("add_f_e", 16'h000F, 16'h000E, 0, 0, 0, 3'b010, 16'h001D, 0, 0, 0);
    step("sub_f_e", 16'h000F, 16'h000E, 1, 0, 1, 3'b010, 16'h0001, 1, 0, 0);
    step("sub_big", 16'd1001, 16'd12341, 1, 0, 1, 3'b010, 16'hD3B4, 0, 0, 0);
    step("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 0, 3'b010, 16'h8000, 0, 0, ovf_en(1'b1));
    step("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 0, 3'b010, 16'h0000, 1, 1, 0);
    // NOR, SLT, SLTU
    step("nor", 16'h0002, 16'h0001, 0, 1, 1, 3'b000, 16'hFFFC, 0, 0, 0);
    step("slt_ovf", 16'h8000, 16'h0001, 1, 0, 1, 3'b011, 16'h0001, 1, 0, ovf_en(1'b1));
    step("slt_5_3", 16'h0005, 16'h0003, 1, 0, 1, 3'b011, 16'h0000, 1, 1, 0);
    step("sltu", 16'h8000, 16'h0001, 1, 0, 1, 3'b110, 16'h0000, 1, 1, 0);
    step("xor", 16'hA5A5, 16'h0FF0, 0, 0, 0, 3'b100, 16'hAA55, 0, 0, 0);

    // Load 0x1234 then reset asynchronously mid-cycle
    step("pass", 16'h0000, 16'h1234, 0, 0, 0, 3'b111, 16'h1234, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    r0.tag = "async_rst";
    check_out(r0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back random ops against the model
    for (int i = 0; i < 8; i++) begin
      step_model($sformatf("b2b%0d", i), 16'($urandom), 16'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 3'(i));
    end
    step_model("slt_raw", 16'h7FFF, 16'h8000, 1'b0, 1'b0, 1'b0, 3'b011);
    step_model("sltu_sub", 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b1, 3'b110);

    if (exp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
